stopwatch_ctrl: RTL and testbench

- Sequencing controller for the 4-digit BCD up/down counter (0000-9999) in the stopwatch datapath.
- Generates the counter's control pulses: en, ld, up, clr and the load value d, from user buttons, a mode select and a prescaled time-base.
- Stops cleanly at the terminal value (9999 counting up, 0000 counting down) using the counter's carry-out, so the count never wraps.

---
 rtl/stopwatch_pkg.sv | 13 +
 rtl/tick_prescaler.sv | 19 +
 rtl/stopwatch_ctrl.sv | 99 +++++++++
 tb/tb_stopwatch_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared FSM states, mode codes, BCD constants and digit clamp for the stopwatch controller
package stopwatch_pkg;
  typedef enum logic [2:0] {S_CLEAR, S_LOAD, S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;
  localparam logic [1:0] MODE_UP0 = 2'd0;
  localparam logic [1:0] MODE_UPP = 2'd1;
  localparam logic [1:0] MODE_DNP = 2'd2;
  localparam logic [1:0] MODE_DN9 = 2'd3;
  localparam logic [15:0] BCD_ZERO = 16'h0000;
  localparam logic [15:0] BCD_MAX = 16'h9999;
  function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: divides clk by TICK_DIV; clear zeroes the count, hold freezes it so a partial tick survives
module tick_prescaler #(
  parameter int TICK_DIV = 1000000,
  parameter int CNT_W = 20
) (
  input  logic clk,
  input  logic clr_n,
  input  logic clear,
  input  logic hold,
  output logic tick
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);
  logic [CNT_W-1:0] cnt;
  assign tick = !clear && !hold && (cnt == LAST);
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (!hold) cnt <= tick ? '0 : cnt + CNT_W'(1);
endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: sequences the 4-digit BCD counter (load, count, pause, stop at terminal value).
// Optional lap display enabled by defining STOPWATCH_LAP_EN.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = 1000000,
  parameter int CNT_W = 20
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        start_stop,
  input  logic        reset_btn,
  input  logic [1:0]  mode,
  input  logic [7:0]  preset,
  input  logic [15:0] ctr_q,
  input  logic        ctr_co,
`ifdef STOPWATCH_LAP_EN
  input  logic        lap,
  output logic        lap_active,
`endif
  output logic        ctr_en,
  output logic        ctr_ld,
  output logic        ctr_up,
  output logic        ctr_clr,
  output logic [15:0] ctr_d,
  output logic [15:0] disp,
  output logic        running,
  output logic        done
);
  state_t state, state_nx;
  logic [1:0] mode_r;
  logic tick, mode_chg, en_nx;
  logic [15:0] load_val;
  assign mode_chg = mode != mode_r;
  assign load_val = (mode == MODE_UP0) ? BCD_ZERO :
                    (mode == MODE_DN9) ? BCD_MAX :
                    {bcd_clamp(preset[7:4]), bcd_clamp(preset[3:0]), 8'h00};
  tick_prescaler #(.TICK_DIV(TICK_DIV), .CNT_W(CNT_W)) u_pre (
    .clk(clk),
    .clr_n(clr_n),
    .clear(state == S_LOAD),
    .hold(state != S_RUN),
    .tick(tick)
  );
  always_comb begin
    state_nx = state;
    case (state)
      S_CLEAR: state_nx = S_LOAD;
      S_LOAD:  state_nx = S_IDLE;
      S_IDLE:  state_nx = (reset_btn || mode_chg) ? S_LOAD : start_stop ? (ctr_co ? S_DONE : S_RUN) : S_IDLE;
      S_RUN:   state_nx = reset_btn ? S_LOAD : start_stop ? S_PAUSE : (tick && ctr_co) ? S_DONE : S_RUN;
      S_PAUSE: state_nx = reset_btn ? S_LOAD : start_stop ? S_RUN : S_PAUSE;
      S_DONE:  state_nx = (reset_btn || mode_chg) ? S_LOAD : S_DONE;
      default: state_nx = S_CLEAR;
    endcase
  end
  // a tick only pulses the counter if we stay in RUN; a tick at the terminal value leaves for DONE
  assign en_nx = (state_nx == S_LOAD) || (state == S_RUN && state_nx == S_RUN && tick);
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) begin
      state   <= S_CLEAR;
      mode_r  <= MODE_UP0;
      ctr_clr <= 1'b1;
      ctr_en  <= 1'b0;
      ctr_ld  <= 1'b0;
      ctr_up  <= 1'b1;
      ctr_d   <= BCD_ZERO;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nx;
      ctr_clr <= 1'b0;
      ctr_en  <= en_nx;
      ctr_ld  <= state_nx == S_LOAD;
      running <= state_nx == S_RUN;
      done    <= state_nx == S_DONE;
      if (state_nx == S_LOAD) begin
        mode_r <= mode;
        ctr_up <= (mode == MODE_UP0) || (mode == MODE_UPP);
        ctr_d  <= load_val;
      end
    end
`ifdef STOPWATCH_LAP_EN
  logic [15:0] lap_q;
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) begin
      lap_active <= 1'b0;
      lap_q      <= BCD_ZERO;
    end else if (state == S_LOAD) lap_active <= 1'b0;
    else if (lap && lap_active) lap_active <= 1'b0;
    else if (lap && state == S_RUN) begin
      lap_active <= 1'b1;
      lap_q      <= ctr_q;
    end
  assign disp = lap_active ? lap_q : ctr_q;
`else
  assign disp = ctr_q;
`endif
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: table-driven check of stopwatch_ctrl against a behavioural BCD counter, TICK_DIV=4
module tb_stopwatch_ctrl;
  logic clk = 1'b0;
  logic clr_n = 1'b1;
  logic start_stop = 1'b0, reset_btn = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [7:0] preset = 8'h00;
  logic [15:0] ctr_q = 16'h0000;
  logic ctr_co;
  logic ctr_en, ctr_ld, ctr_up, ctr_clr, running, done;
  logic [15:0] ctr_d, disp;
`ifdef STOPWATCH_LAP_EN
  logic lap = 1'b0;
  logic lap_active;
`endif
  int nvec = 0, nerr = 0;

  stopwatch_ctrl #(.TICK_DIV(4), .CNT_W(3)) dut (
    .clk(clk), .clr_n(clr_n), .start_stop(start_stop), .reset_btn(reset_btn),
    .mode(mode), .preset(preset), .ctr_q(ctr_q), .ctr_co(ctr_co),
`ifdef STOPWATCH_LAP_EN
    .lap(lap), .lap_active(lap_active),
`endif
    .ctr_en(ctr_en), .ctr_ld(ctr_ld), .ctr_up(ctr_up), .ctr_clr(ctr_clr),
    .ctr_d(ctr_d), .disp(disp), .running(running), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] bcd_step(input logic [15:0] v, input logic up);
    logic [15:0] r = v;
    for (int i = 0; i < 4; i++) begin
      if (up ? r[4*i+:4] == 4'd9 : r[4*i+:4] == 4'd0) r[4*i+:4] = up ? 4'd0 : 4'd9;
      else begin
        r[4*i+:4] = up ? r[4*i+:4] + 4'd1 : r[4*i+:4] - 4'd1;
        break;
      end
    end
    return r;
  endfunction

  always @(posedge clk or posedge ctr_clr)
    if (ctr_clr) ctr_q <= 16'h0000;
    else if (ctr_en) ctr_q <= ctr_ld ? ctr_d : bcd_step(ctr_q, ctr_up);
  assign ctr_co = ctr_up ? (ctr_q == 16'h9999) : (ctr_q == 16'h0000);

  typedef struct {
    logic ss, rb;
    logic [1:0] md;
    logic [7:0] pre;
    logic en, ld, up;
    logic [15:0] d;
    logic run, dn;
    logic [15:0] dsp;
  } vec_t;
  vec_t tbl[29];

  function automatic vec_t mk(input logic ss, rb, input logic [1:0] md, input logic [7:0] pre,
                              input logic en, ld, up, input logic [15:0] d, input logic run, dn,
                              input logic [15:0] dsp);
    vec_t v;
    v.ss = ss; v.rb = rb; v.md = md; v.pre = pre; v.en = en; v.ld = ld; v.up = up;
    v.d = d; v.run = run; v.dn = dn; v.dsp = dsp;
    return v;
  endfunction

  function automatic logic [63:0] outs();
    return {26'd0, ctr_clr, ctr_en, ctr_ld, ctr_up, ctr_d, running, done, disp};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int en_cnt;
    tbl[0]  = mk(0,0,2'd0,8'h00, 1,1,1,16'h0000, 0,0,16'h0000);
    tbl[1]  = mk(0,0,2'd0,8'h00, 0,0,1,16'h0000, 0,0,16'h0000);
    tbl[2]  = mk(0,0,2'd1,8'h12, 1,1,1,16'h1200, 0,0,16'h0000);
    tbl[3]  = mk(0,0,2'd1,8'h12, 0,0,1,16'h1200, 0,0,16'h1200);
    tbl[4]  = mk(1,0,2'd1,8'h12, 0,0,1,16'h1200, 1,0,16'h1200);
    tbl[5]  = mk(0,0,2'd1,8'h12, 0,0,1,16'h1200, 1,0,16'h1200);
    tbl[6]  = mk(0,0,2'd1,8'h12, 0,0,1,16'h1200, 1,0,16'h1200);
    tbl[7]  = mk(0,0,2'd1,8'h12, 0,0,1,16'h1200, 1,0,16'h1200);
    tbl[8]  = mk(0,0,2'd1,8'h12, 1,0,1,16'h1200, 1,0,16'h1200);
    tbl[9]  = mk(0,0,2'd1,8'h12, 0,0,1,16'h1200, 1,0,16'h1201);
    tbl[10] = mk(0,0,2'd1,8'h12, 0,0,1,16'h1200, 1,0,16'h1201);
    tbl[11] = mk(0,0,2'd1,8'h12, 0,0,1,16'h1200, 1,0,16'h1201);
    tbl[12] = mk(0,0,2'd1,8'h12, 1,0,1,16'h1200, 1,0,16'h1201);
    tbl[13] = mk(0,0,2'd1,8'h12, 0,0,1,16'h1200, 1,0,16'h1202);
    tbl[14] = mk(1,0,2'd1,8'h12, 0,0,1,16'h1200, 0,0,16'h1202);
    tbl[15] = mk(0,0,2'd1,8'h12, 0,0,1,16'h1200, 0,0,16'h1202);
    tbl[16] = mk(1,0,2'd1,8'h12, 0,0,1,16'h1200, 1,0,16'h1202);
    tbl[17] = mk(0,0,2'd1,8'h12, 0,0,1,16'h1200, 1,0,16'h1202);
    tbl[18] = mk(0,0,2'd1,8'h12, 1,0,1,16'h1200, 1,0,16'h1202);
    tbl[19] = mk(0,0,2'd1,8'h12, 0,0,1,16'h1200, 1,0,16'h1203);
    tbl[20] = mk(1,1,2'd1,8'hF3, 1,1,1,16'h9300, 0,0,16'h1203);
    tbl[21] = mk(0,0,2'd1,8'hF3, 0,0,1,16'h9300, 0,0,16'h9300);
    tbl[22] = mk(0,0,2'd2,8'h00, 1,1,0,16'h0000, 0,0,16'h9300);
    tbl[23] = mk(0,0,2'd2,8'h00, 0,0,0,16'h0000, 0,0,16'h0000);
    tbl[24] = mk(1,0,2'd2,8'h00, 0,0,0,16'h0000, 0,1,16'h0000);
    tbl[25] = mk(1,0,2'd2,8'h00, 0,0,0,16'h0000, 0,1,16'h0000);
    tbl[26] = mk(0,0,2'd2,8'h00, 0,0,0,16'h0000, 0,1,16'h0000);
    tbl[27] = mk(0,0,2'd3,8'h00, 1,1,0,16'h9999, 0,0,16'h0000);
    tbl[28] = mk(0,0,2'd3,8'h00, 0,0,0,16'h9999, 0,0,16'h9999);

    #2 clr_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_state", outs(), {26'd0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000});
    clr_n = 1'b1;
    #1 chk("clr_before_edge", {63'd0, ctr_clr}, 64'd1);
    for (int i = 0; i < 29; i++) begin
      start_stop = tbl[i].ss;
      reset_btn  = tbl[i].rb;
      mode       = tbl[i].md;
      preset     = tbl[i].pre;
      step();
      chk($sformatf("row%0d", i), outs(),
          {26'd0, 1'b0, tbl[i].en, tbl[i].ld, tbl[i].up, tbl[i].d, tbl[i].run, tbl[i].dn, tbl[i].dsp});
    end
    start_stop = 1'b0;
    reset_btn = 1'b0;

    mode = 2'd0;
    step();
    chk("m0_load", {47'd0, ctr_en, ctr_ld, ctr_d}, {47'd0, 1'b1, 1'b1, 16'h0000});
    step();
    start_stop = 1'b1;
    step();
    start_stop = 1'b0;
    chk("m0_running", {63'd0, running}, 64'd1);
    en_cnt = 0;
    for (int c = 0; c < 41000 && !done; c++) begin
      step();
      if (ctr_en && !ctr_ld) en_cnt++;
    end
    chk("m0_done", {63'd0, done}, 64'd1);
    chk("m0_en_count", 64'(en_cnt), 64'd9999);
    chk("m0_terminal", {48'd0, ctr_q}, {48'd0, 16'h9999});
    start_stop = 1'b1;
    step();
    start_stop = 1'b0;
    en_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (ctr_en) en_cnt++;
    end
    chk("m0_hold_no_en", 64'(en_cnt), 64'd0);
    chk("m0_no_wrap", {47'd0, done, ctr_q}, {47'd0, 1'b1, 16'h9999});

    reset_btn = 1'b1;
    step();
    reset_btn = 1'b0;
    chk("done_reset_btn", {46'd0, ctr_en, ctr_ld, done, ctr_d}, {46'd0, 1'b1, 1'b1, 1'b0, 16'h0000});
    step();
    start_stop = 1'b1;
    step();
    start_stop = 1'b0;
    step();
    step();
    clr_n = 1'b0;
    #1 chk("midop_reset", outs(), {26'd0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000});
    @(negedge clk);
    clr_n = 1'b1;
    #1 chk("midop_clr_held", {63'd0, ctr_clr}, 64'd1);
    step();
    chk("midop_relaunch", {61'd0, ctr_clr, ctr_en, ctr_ld}, {61'd0, 1'b0, 1'b1, 1'b1});
    step();
    chk("midop_idle", {61'd0, ctr_en, running, done}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
